// File: rtl/proc_dmem.sv
// Data memory beside the processor: byte-masked stores, combinational loads,
// a req/ack debug/loader port and a whole-array clear engine. Optional store counter: DMEM_WRCNT_EN.
module proc_dmem #(
    parameter int DATA_DEP      = 512,
    parameter int DATA_ADDR_WID = 29
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [31:0]              addr,
    input  logic                     wr_en,
    input  logic [63:0]              wdata,
    input  logic [7:0]               wmask,
    output logic [63:0]              rdata,
    input  logic                     dbg_req,
    input  logic                     dbg_we,
    input  logic [DATA_ADDR_WID-1:0] dbg_addr,
    input  logic [63:0]              dbg_wdata,
    output logic                     dbg_ack,
    output logic [63:0]              dbg_rdata,
    input  logic                     clr_start,
    output logic                     busy,
    output logic [1:0]               err
`ifdef DMEM_WRCNT_EN
    ,
    output logic [31:0]              wr_cnt
`endif
);

    localparam int IDX_WID = $clog2(DATA_DEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        CLR  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_WID-1:0]   clr_idx_q, clr_idx_d;
    logic [63:0]          dbg_rdata_q, dbg_rdata_d;
    logic [1:0]           err_q, err_d;

    logic [63:0]          mem [DATA_DEP];

    logic [IDX_WID-1:0]   proc_idx;
    logic [IDX_WID-1:0]   dbg_idx;
    logic                 proc_in_range;
    logic                 dbg_in_range;
    logic                 proc_store;
    logic                 unused_addr_bits;

    logic                 mem_we;
    logic [IDX_WID-1:0]   mem_idx;
    logic [63:0]          mem_wdata;
    logic [7:0]           mem_be;
    logic [63:0]          mem_old;
    logic [63:0]          mem_merged;

    assign proc_idx         = addr[IDX_WID+2:3];
    assign dbg_idx          = dbg_addr[IDX_WID-1:0];
    assign proc_in_range    = addr[31:3] < DATA_ADDR_WID'(DATA_DEP);
    assign dbg_in_range     = dbg_addr < DATA_ADDR_WID'(DATA_DEP);
    assign unused_addr_bits = ^addr[2:0];

    // A store is only performed outside CLR, in range, and with at least one lane enabled.
    assign proc_store = wr_en && (state_q != CLR) && proc_in_range && (wmask != 8'h00);

    assign rdata     = proc_in_range ? mem[proc_idx] : 64'h0;
    assign dbg_ack   = (state_q == ACK);
    assign dbg_rdata = dbg_rdata_q;
    assign busy      = (state_q == CLR);
    assign err       = err_q;

    // Single write port: the state machine guarantees at most one writer per cycle.
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = proc_idx;
        mem_wdata = wdata;
        mem_be    = 8'h00;
        if (state_q == CLR) begin
            mem_we    = 1'b1;
            mem_idx   = clr_idx_q;
            mem_wdata = 64'h0;
            mem_be    = 8'hFF;
        end else if (proc_store) begin
            mem_we    = 1'b1;
            mem_be    = wmask;
        end else if (state_q == IDLE && !clr_start && !wr_en && dbg_req && dbg_we && dbg_in_range) begin
            mem_we    = 1'b1;
            mem_idx   = dbg_idx;
            mem_wdata = dbg_wdata;
            mem_be    = 8'hFF;
        end
    end

    assign mem_old = mem[mem_idx];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign mem_merged[8*gi +: 8] = mem_be[gi] ? mem_wdata[8*gi +: 8] : mem_old[8*gi +: 8];
        end
    endgenerate

    // Reset blocks array writes so an aborted clear leaves the current word untouched.
    always_ff @(posedge clk) begin
        if (mem_we && !nrst) begin
            mem[mem_idx] <= mem_merged;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        dbg_rdata_d = dbg_rdata_q;
        err_d       = err_q;
        if (wr_en) begin
            if (state_q == CLR) begin
                err_d[1] = 1'b1;
            end else if (!proc_in_range) begin
                err_d[0] = 1'b1;
            end
        end
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLR;
                end else if (dbg_req && !wr_en) begin
                    state_d = ACK;
                    if (!dbg_we) begin
                        dbg_rdata_d = dbg_in_range ? mem[dbg_idx] : 64'h0;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            CLR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IDX_WID'(DATA_DEP - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q     <= IDLE;
            clr_idx_q   <= '0;
            dbg_rdata_q <= 64'h0;
            err_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            dbg_rdata_q <= dbg_rdata_d;
            err_q       <= err_d;
        end
    end

`ifdef DMEM_WRCNT_EN
    logic [31:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (proc_store && wr_cnt_q != 32'hFFFF_FFFF) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            wr_cnt_q <= 32'h0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign wr_cnt = wr_cnt_q;
`endif

endmodule
